vsync_skew_monitor: RTL and testbench
=====================================

VSYNC_SKEW_MONITOR -- requirements
Module: vsync_skew_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of the skew counter in clk cycles.
REQ-002 SHALL have parameter TOL, default 4, maximum tolerated skew in clk cycles.
REQ-003 SHALL have parameter TIMEOUT, default 1000000, maximum measurable skew in clk cycles.
REQ-004 SHALL have parameter MAX_SKEW, default 4096, clamp applied to skew before the correction length is computed.
REQ-005 SHALL have parameter CORR_SCALE, default 10, clk cycles of err per clk cycle of skew.
REQ-006 SHALL have port clk, input, 1, the 240 MHz clock shared with the 24 MHz generator.
REQ-007 SHALL have port reset_n, input, 1, reset; reset reset_n, asynchronous, active-low; clock clk.
REQ-008 SHALL have port enable, input, 1, synchronous run enable.
REQ-009 SHALL have ports vsync_0 and vsync_1, input, 1 each, camera vsync, asynchronous to clk.
REQ-010 SHALL have ports err_ch0 and err_ch1, output, 1 each, request to speed up the lagging channel's 24 MHz clock.
REQ-011 SHALL have port locked, output, 1, high when the last valid measurement was within TOL.

Function
REQ-012 SHALL pass each vsync through a 2-FF synchroniser plus a rising-edge detector, giving single-cycle pulses r0 and r1 three clk cycles after the input edge.
REQ-013 SHALL implement the states WAIT_EDGE, MEAS_0, MEAS_1, CORR_0 and CORR_1.
REQ-014 In WAIT_EDGE: r0&r1 in the same cycle SHALL mean skew=0 (locked=1, stay); r0 alone SHALL go to MEAS_0 with cnt=0; r1 alone SHALL go to MEAS_1 with cnt=0.
REQ-015 In MEAS_0, cnt SHALL increment every cycle, saturating at 2^CNT_W-1.
REQ-016 In MEAS_0, on r1 the skew SHALL be cnt+1.
REQ-017 In MEAS_0, if skew>TOL the block SHALL go to CORR_1 (ch1 lags) with locked=0; otherwise it SHALL set locked=1 and return to WAIT_EDGE.
REQ-018 MEAS_1 SHALL mirror MEAS_0 with channels swapped, leading to CORR_0.
REQ-019 In MEAS_x, a repeat edge of the leading channel before the lagging edge SHALL restart cnt at 0 and stay in MEAS_x.
REQ-020 In MEAS_x, r0&r1 together SHALL be treated as the lagging edge.
REQ-021 In MEAS_x, when cnt reaches TIMEOUT-1 the block SHALL return to WAIT_EDGE with locked=0 and no correction.
REQ-022 On entry to CORR_x, corr_cnt SHALL load min(skew,MAX_SKEW)*CORR_SCALE.
REQ-023 corr_cnt SHALL be wide enough to hold MAX_SKEW*CORR_SCALE without truncation.
REQ-024 In CORR_x, err_chx SHALL be 1 and corr_cnt SHALL decrement each cycle; at corr_cnt==1 the block SHALL return to WAIT_EDGE.
REQ-025 err_chx SHALL be high for exactly the loaded number of cycles.
REQ-026 Vsync edges during CORR_x SHALL be ignored.
REQ-027 err_ch0 and err_ch1 SHALL be registered, glitch-free and never high simultaneously.
REQ-028 Deasserting enable in any state SHALL force WAIT_EDGE on the next edge, err_ch0=err_ch1=0, locked=0 and cnt=0; the synchronisers SHALL keep running.

Reset
REQ-029 On reset_n low the block SHALL asynchronously clear err_ch0, err_ch1, locked, cnt, corr_cnt and the synchroniser flops, and set the state to WAIT_EDGE.
REQ-030 Reset asserted mid-CORR SHALL drop err immediately.

Configuration
REQ-031 With VSYNC_SKEW_STAT_EN defined, the block SHALL add outputs skew_val[CNT_W-1:0] (last measured skew, 0 after reset, updated on each valid measurement), skew_lead (0 when ch0 leads) and a 16-bit saturating timeout_cnt counting REQ-021 events.
REQ-032 Without VSYNC_SKEW_STAT_EN, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package vsync_skew_pkg SHALL hold the state enum (3-bit encoding) and the default parameter constants.
REQ-034 Sub-module sync_edge (2-FF synchroniser plus rising-edge pulse) SHALL be instantiated once per vsync channel.

Verification
REQ-035 Bench SHALL cover: vsync_0 edge, vsync_1 edge 2 cycles later -> locked=1, no err.
REQ-036 Bench SHALL cover: vsync_0 edge, vsync_1 edge 100 cycles later -> err_ch1 high for exactly 1000 cycles, err_ch0 stays 0, locked=0.
REQ-037 Bench SHALL cover: vsync_1 leads by 10000 cycles -> err_ch0 high for 40960 cycles (MAX_SKEW clamp).
REQ-038 Bench SHALL cover: vsync_0 edge only, no vsync_1 -> return to WAIT_EDGE after 1000000 cycles, no err, timeout_cnt=1 (macro on).
REQ-039 Bench SHALL cover: enable dropped 50 cycles into CORR_1 -> err_ch1 low next cycle; reset_n pulsed mid-CORR_0 -> err_ch0 low asynchronously.
REQ-040 Bench SHALL cover: both vsync edges in the same cycle -> locked=1; in STAT build, skew_val=0.

Source files
------------

// File: rtl/vsync_skew_pkg.sv
// Shared types and default constants for the vsync skew monitor.
// Optional statistics outputs are enabled with VSYNC_SKEW_STAT_EN.
package vsync_skew_pkg;

    localparam int DEF_CNT_W      = 24;
    localparam int DEF_TOL        = 4;
    localparam int DEF_TIMEOUT    = 1000000;
    localparam int DEF_MAX_SKEW   = 4096;
    localparam int DEF_CORR_SCALE = 10;

    typedef enum logic [2:0] {
        S_WAIT_EDGE = 3'd0,
        S_MEAS_0    = 3'd1,
        S_MEAS_1    = 3'd2,
        S_CORR_0    = 3'd3,
        S_CORR_1    = 3'd4
    } state_t;

endpackage

// File: rtl/vsync_skew_monitor_sync_edge.sv
// 2-FF synchroniser followed by a registered rising-edge pulse; the pulse
// appears three clk cycles after the asynchronous input rises.
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/vsync_skew_monitor.sv
// Measures the skew between two camera vsyncs and requests a speed-up of the
// lagging channel's clock. Define VSYNC_SKEW_STAT_EN for skew_val/skew_lead/timeout_cnt.
module vsync_skew_monitor
    import vsync_skew_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TOL        = DEF_TOL,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int MAX_SKEW   = DEF_MAX_SKEW,
    parameter int CORR_SCALE = DEF_CORR_SCALE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             vsync_0,
    input  logic             vsync_1,
    output logic             err_ch0,
    output logic             err_ch1,
    output logic             locked,
    output logic [2:0]       fsm_state
`ifdef VSYNC_SKEW_STAT_EN
    ,
    output logic [CNT_W-1:0] skew_val,
    output logic             skew_lead,
    output logic [15:0]      timeout_cnt
`endif
);

    localparam int SK_W   = $clog2(MAX_SKEW + 1);
    localparam int CORR_W = $clog2(MAX_SKEW * CORR_SCALE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]   MAX_V   = (CNT_W + 1)'(MAX_SKEW);

    logic              r0;
    logic              r1;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CORR_W-1:0] corr_cnt;

    sync_edge u_sync_0 (.clk(clk), .reset_n(reset_n), .din(vsync_0), .pulse(r0));
    sync_edge u_sync_1 (.clk(clk), .reset_n(reset_n), .din(vsync_1), .pulse(r1));

    // Skew is one past the cycles already counted; kept one bit wider so a
    // saturated counter cannot wrap before the clamp.
    logic [CNT_W:0]    skew_meas;
    logic [SK_W-1:0]   skew_clamp;
    logic [CORR_W-1:0] corr_load;
    logic              lag_edge;
    logic              lead_edge;

    assign skew_meas  = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign skew_clamp = (skew_meas > MAX_V) ? MAX_V[SK_W-1:0] : skew_meas[SK_W-1:0];
    assign corr_load  = CORR_W'(skew_clamp) * CORR_W'(CORR_SCALE);
    assign lag_edge   = (state == S_MEAS_0) ? r1 : r0;
    assign lead_edge  = (state == S_MEAS_0) ? (r0 & ~r1) : (r1 & ~r0);
    assign fsm_state  = state;

`ifdef VSYNC_SKEW_STAT_EN
    logic [CNT_W-1:0] skew_sat;
    assign skew_sat = skew_meas[CNT_W] ? CNT_MAX : skew_meas[CNT_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_WAIT_EDGE;
            cnt      <= '0;
            corr_cnt <= '0;
            err_ch0  <= 1'b0;
            err_ch1  <= 1'b0;
            locked   <= 1'b0;
`ifdef VSYNC_SKEW_STAT_EN
            skew_val    <= '0;
            skew_lead   <= 1'b0;
            timeout_cnt <= '0;
`endif
        end else if (!enable) begin
            state    <= S_WAIT_EDGE;
            cnt      <= '0;
            corr_cnt <= '0;
            err_ch0  <= 1'b0;
            err_ch1  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            case (state)
                S_WAIT_EDGE: begin
                    cnt <= '0;
                    if (r0 && r1) begin
                        locked <= 1'b1;
`ifdef VSYNC_SKEW_STAT_EN
                        skew_val  <= '0;
                        skew_lead <= 1'b0;
`endif
                    end else if (r0) begin
                        state <= S_MEAS_0;
                    end else if (r1) begin
                        state <= S_MEAS_1;
                    end
                end
                S_MEAS_0, S_MEAS_1: begin
                    if (lag_edge) begin
                        cnt <= '0;
`ifdef VSYNC_SKEW_STAT_EN
                        skew_val  <= skew_sat;
                        skew_lead <= (state == S_MEAS_1);
`endif
                        if (skew_meas > TOL_V) begin
                            locked   <= 1'b0;
                            corr_cnt <= corr_load;
                            if (state == S_MEAS_0) begin
                                state   <= S_CORR_1;
                                err_ch1 <= 1'b1;
                            end else begin
                                state   <= S_CORR_0;
                                err_ch0 <= 1'b1;
                            end
                        end else begin
                            locked <= 1'b1;
                            state  <= S_WAIT_EDGE;
                        end
                    end else if (lead_edge) begin
                        cnt <= '0;
                    end else if (cnt == TO_V) begin
                        cnt    <= '0;
                        locked <= 1'b0;
                        state  <= S_WAIT_EDGE;
`ifdef VSYNC_SKEW_STAT_EN
                        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
`endif
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CORR_0, S_CORR_1: begin
                    // err was raised on entry, so the last active cycle is corr_cnt==1.
                    if (corr_cnt == CORR_W'(1)) begin
                        corr_cnt <= '0;
                        err_ch0  <= 1'b0;
                        err_ch1  <= 1'b0;
                        state    <= S_WAIT_EDGE;
                    end else begin
                        corr_cnt <= corr_cnt - CORR_W'(1);
                    end
                end
                default: state <= S_WAIT_EDGE;
            endcase
        end
    end

endmodule

// File: tb/tb_vsync_skew_monitor.sv
// Directed bench for vsync_skew_monitor; error pulses are checked against a
// queue of expected {channel, length} entries. STAT outputs with VSYNC_SKEW_STAT_EN.
module tb_vsync_skew_monitor;
    import vsync_skew_pkg::*;

    localparam int CNT_W   = 24;
    localparam int TIMEOUT = 12000;

    logic clk = 1'b0;
    logic reset_n, enable, vsync_0, vsync_1;
    logic err_ch0, err_ch1, locked;
    logic [2:0] fsm_state;
`ifdef VSYNC_SKEW_STAT_EN
    logic [CNT_W-1:0] skew_val;
    logic skew_lead;
    logic [15:0] timeout_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic mon_en = 1'b0;
    int run0 = 0;
    int run1 = 0;

    vsync_skew_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .vsync_0(vsync_0), .vsync_1(vsync_1),
        .err_ch0(err_ch0), .err_ch1(err_ch1), .locked(locked),
        .fsm_state(fsm_state)
`ifdef VSYNC_SKEW_STAT_EN
        , .skew_val(skew_val), .skew_lead(skew_lead), .timeout_cnt(timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic ch, input int len);
        logic [31:0] exp;
        check("pulse expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("pulse channel", ch, exp[31]);
            check("pulse length", len, exp[30:0]);
        end
    endtask

    // Pulse-width monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!mon_en) begin
            run0 = 0;
            run1 = 0;
        end else begin
            check("err exclusive", err_ch0 & err_ch1, 0);
            if (err_ch0) run0++;
            else if (run0 != 0) begin pulse_done(1'b0, run0); run0 = 0; end
            if (err_ch1) run1++;
            else if (run1 != 0) begin pulse_done(1'b1, run1); run1 = 0; end
        end
    end

    // lead_ch rises first, the other channel gap cycles later.
    task automatic drive_pair(input int lead_ch, input int gap);
        vsync_0 = 1'b0;
        vsync_1 = 1'b0;
        tick(6);
        if (lead_ch == 0) vsync_0 = 1'b1; else vsync_1 = 1'b1;
        tick(gap);
        vsync_0 = 1'b1;
        vsync_1 = 1'b1;
    endtask

    task automatic settle(input string tag, input int max);
        int k = 0;
        tick(8);
        while (fsm_state != S_WAIT_EDGE && k < max) begin
            tick(1);
            k++;
        end
        check({tag, " idle"}, fsm_state, S_WAIT_EDGE);
        tick(3);
        check({tag, " queue drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        enable  = 1'b1;
        vsync_0 = 1'b0;
        vsync_1 = 1'b0;
        tick(4);
        check("reset err_ch0", err_ch0, 0);
        check("reset err_ch1", err_ch1, 0);
        check("reset locked", locked, 0);
        check("reset state", fsm_state, S_WAIT_EDGE);
        reset_n = 1'b1;
        tick(2);
        mon_en = 1'b1;

        drive_pair(0, 2);
        settle("skew2", 50);
        check("skew2 locked", locked, 1);
`ifdef VSYNC_SKEW_STAT_EN
        check("skew2 skew_val", skew_val, 2);
        check("skew2 skew_lead", skew_lead, 0);
`endif

        vsync_0 = 1'b0;
        vsync_1 = 1'b0;
        tick(6);
        vsync_0 = 1'b1;
        k = 0;
        while (fsm_state != S_MEAS_0 && k < 10) begin tick(1); k++; end
        check("timeout entered meas", fsm_state, S_MEAS_0);
        k = 0;
        while (fsm_state == S_MEAS_0 && k < TIMEOUT + 10) begin tick(1); k++; end
        check("timeout cycles", k, TIMEOUT);
        check("timeout state", fsm_state, S_WAIT_EDGE);
        check("timeout locked", locked, 0);
        check("timeout no err", err_ch0 | err_ch1, 0);
`ifdef VSYNC_SKEW_STAT_EN
        check("timeout_cnt", timeout_cnt, 1);
`endif

        drive_pair(0, 0);
        settle("same cycle", 50);
        check("same cycle locked", locked, 1);
`ifdef VSYNC_SKEW_STAT_EN
        check("same cycle skew_val", skew_val, 0);
`endif

        drive_pair(1, 3);
        settle("ch1 lead 3", 50);
        check("ch1 lead 3 locked", locked, 1);
`ifdef VSYNC_SKEW_STAT_EN
        check("ch1 lead 3 skew_val", skew_val, 3);
        check("ch1 lead 3 skew_lead", skew_lead, 1);
`endif

        drive_pair(0, 4);
        settle("tol edge", 50);
        check("tol edge locked", locked, 1);

        drive_pair(1, 5);
        exp_q.push_back({1'b0, 31'd50});
        settle("tol+1", 200);
        check("tol+1 locked", locked, 0);

        drive_pair(0, 100);
        exp_q.push_back({1'b1, 31'd1000});
        settle("skew100", 2000);
        check("skew100 locked", locked, 0);
`ifdef VSYNC_SKEW_STAT_EN
        check("skew100 skew_val", skew_val, 100);
`endif

        drive_pair(1, 10000);
        exp_q.push_back({1'b0, 31'd40960});
        settle("clamp", 45000);
`ifdef VSYNC_SKEW_STAT_EN
        check("clamp skew_val", skew_val, 10000);
        check("clamp skew_lead", skew_lead, 1);
`endif

        // Repeat leading edge restarts the measurement.
        vsync_0 = 1'b0;
        vsync_1 = 1'b0;
        tick(6);
        vsync_0 = 1'b1;
        tick(5);
        vsync_0 = 1'b0;
        tick(5);
        vsync_0 = 1'b1;
        tick(7);
        vsync_1 = 1'b1;
        exp_q.push_back({1'b1, 31'd70});
        settle("restart", 300);

        mon_en = 1'b0;
        drive_pair(0, 10);
        k = 0;
        while (!err_ch1 && k < 20) begin tick(1); k++; end
        tick(50);
        check("abort err_ch1 before", err_ch1, 1);
        enable = 1'b0;
        tick(1);
        check("abort err_ch1 after", err_ch1, 0);
        check("abort err_ch0 after", err_ch0, 0);
        check("abort locked", locked, 0);
        check("abort state", fsm_state, S_WAIT_EDGE);
        tick(3);
        enable  = 1'b1;
        vsync_0 = 1'b0;
        vsync_1 = 1'b0;
        tick(6);

        drive_pair(1, 10);
        k = 0;
        while (!err_ch0 && k < 20) begin tick(1); k++; end
        tick(20);
        check("reset mid-corr err_ch0 before", err_ch0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset mid-corr err_ch0", err_ch0, 0);
        check("reset mid-corr state", fsm_state, S_WAIT_EDGE);
        check("reset mid-corr locked", locked, 0);
        vsync_0 = 1'b0;
        vsync_1 = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("post reset idle", fsm_state, S_WAIT_EDGE);
        check("post reset err", err_ch0 | err_ch1, 0);
`ifdef VSYNC_SKEW_STAT_EN
        check("post reset skew_val", skew_val, 0);
        check("post reset timeout_cnt", timeout_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
